// File: rtl/klotski_move_sequencer.sv
// Move queue and dispatcher feeding the Klotski block-movement stage.
// Issues queued moves one at a time, then waits for done and a settle gap before the next.
module klotski_move_sequencer #(
    parameter int DEPTH          = 16,
    parameter int SETTLE_CYCLES  = 2_500_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       i_Clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [4:0] i_push_start,
    input  logic [4:0] i_push_end,
    input  logic       i_go,
    input  logic       i_abort,
    input  logic       i_move_done,
    output logic       o_move_en,
    output logic [4:0] o_start_block,
    output logic [4:0] o_end_block,
    output logic       o_busy,
    output logic       o_all_done,
    output logic       o_empty,
    output logic       o_full,
    output logic [7:0] o_moves_done,
    output logic       o_err_move,
    output logic       o_err_timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        SETTLE
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;
    logic               move_en_q, move_en_d;
    logic [4:0]         start_q, start_d;
    logic [4:0]         end_q, end_d;
    logic               all_done_q, all_done_d;
    logic [7:0]         moves_done_q, moves_done_d;
    logic               err_move_q, err_move_d;
    logic               err_timeout_q, err_timeout_d;
    logic               abort_pending_q, abort_pending_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic [9:0]         head;
    logic               push_valid;
    logic               push_ok;
    logic               pop;
    logic               flush;

    assign head       = mem_q[rd_ptr_q];
    assign push_valid = (i_push_start <= 5'd19) && (i_push_end <= 5'd19) &&
                        (i_push_start != i_push_end);

    always_comb begin
        state_d         = state_q;
        move_en_d       = 1'b0;
        all_done_d      = 1'b0;
        start_d         = start_q;
        end_d           = end_q;
        moves_done_d    = moves_done_q;
        err_move_d      = err_move_q;
        err_timeout_d   = err_timeout_q;
        abort_pending_d = abort_pending_q;
        settle_cnt_d    = settle_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        pop             = 1'b0;
        flush           = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_abort) begin
                    flush = 1'b1;
                end else if (i_go) begin
                    err_move_d    = 1'b0;
                    err_timeout_d = 1'b0;
                    if (count_q != '0) begin
                        state_d      = ISSUE;
                        move_en_d    = 1'b1;
                        start_d      = head[9:5];
                        end_d        = head[4:0];
                        moves_done_d = 8'd0;
                    end else begin
                        all_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                pop = (count_q != '0);
                if (i_abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d   = WAIT_DONE;
                    tmo_cnt_d = '0;
                end
            end
            WAIT_DONE: begin
                // Abort cannot drop the piece mid-move, so it only flags the run.
                if (i_abort) begin
                    flush           = 1'b1;
                    abort_pending_d = 1'b1;
                end
                if (i_move_done) begin
                    if (moves_done_q != 8'hFF) begin
                        moves_done_d = moves_done_q + 8'd1;
                    end
                    if (abort_pending_q || i_abort) begin
                        state_d         = IDLE;
                        abort_pending_d = 1'b0;
                    end else begin
                        state_d      = SETTLE;
                        settle_cnt_d = '0;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    flush           = 1'b1;
                    err_timeout_d   = 1'b1;
                    abort_pending_d = 1'b0;
                    state_d         = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            SETTLE: begin
                if (i_abort) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    if (count_q != '0) begin
                        state_d   = ISSUE;
                        move_en_d = 1'b1;
                        start_d   = head[9:5];
                        end_d     = head[4:0];
                    end else begin
                        state_d    = IDLE;
                        all_done_d = 1'b1;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot a full-queue push needs.
        push_ok = i_push && push_valid && !flush &&
                  ((count_q != CNT_W'(DEPTH)) || pop);
        if (i_push && !flush && !push_ok) begin
            err_move_d = 1'b1;
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge i_Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {i_push_start, i_push_end};
        end
    end

    always_ff @(posedge i_Clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= IDLE;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            move_en_q       <= 1'b0;
            start_q         <= 5'd0;
            end_q           <= 5'd0;
            all_done_q      <= 1'b0;
            moves_done_q    <= 8'd0;
            err_move_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
            abort_pending_q <= 1'b0;
            settle_cnt_q    <= '0;
            tmo_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            empty_q         <= empty_d;
            full_q          <= full_d;
            move_en_q       <= move_en_d;
            start_q         <= start_d;
            end_q           <= end_d;
            all_done_q      <= all_done_d;
            moves_done_q    <= moves_done_d;
            err_move_q      <= err_move_d;
            err_timeout_q   <= err_timeout_d;
            abort_pending_q <= abort_pending_d;
            settle_cnt_q    <= settle_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
        end
    end

    assign o_move_en     = move_en_q;
    assign o_start_block = start_q;
    assign o_end_block   = end_q;
    assign o_busy        = (state_q != IDLE);
    assign o_all_done    = all_done_q;
    assign o_empty       = empty_q;
    assign o_full        = full_q;
    assign o_moves_done  = moves_done_q;
    assign o_err_move    = err_move_q;
    assign o_err_timeout = err_timeout_q;

endmodule

// File: tb/tb_klotski_move_sequencer.sv
// Directed bench for klotski_move_sequencer with a small settle gap, short timeout and 4-deep queue.
module tb_klotski_move_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_rst;
    logic       i_push;
    logic [4:0] i_push_start;
    logic [4:0] i_push_end;
    logic       i_go;
    logic       i_abort;
    logic       i_move_done;
    logic       o_move_en;
    logic [4:0] o_start_block;
    logic [4:0] o_end_block;
    logic       o_busy;
    logic       o_all_done;
    logic       o_empty;
    logic       o_full;
    logic [7:0] o_moves_done;
    logic       o_err_move;
    logic       o_err_timeout;

    int checks   = 0;
    int failures = 0;

    int         en_cnt;
    int         ad_cnt;
    int         ad_cyc;
    int         en_cyc [8];
    logic [4:0] en_s [8];
    logic [4:0] en_e [8];

    klotski_move_sequencer #(
        .DEPTH         (4),
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_Clk        (i_Clk),
        .i_rst        (i_rst),
        .i_push       (i_push),
        .i_push_start (i_push_start),
        .i_push_end   (i_push_end),
        .i_go         (i_go),
        .i_abort      (i_abort),
        .i_move_done  (i_move_done),
        .o_move_en    (o_move_en),
        .o_start_block(o_start_block),
        .o_end_block  (o_end_block),
        .o_busy       (o_busy),
        .o_all_done   (o_all_done),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_moves_done (o_moves_done),
        .o_err_move   (o_err_move),
        .o_err_timeout(o_err_timeout)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic push_move(input logic [4:0] s, input logic [4:0] e);
        i_push       = 1'b1;
        i_push_start = s;
        i_push_end   = e;
        tick();
        i_push = 1'b0;
    endtask

    // Movement-stage model: answers each enable with done 'delay' cycles later.
    task automatic run_model(input int ncycles, input int delay);
        int last_en;
        last_en = -1000;
        en_cnt  = 0;
        ad_cnt  = 0;
        ad_cyc  = -1;
        for (int c = 1; c <= ncycles; c++) begin
            tick();
            i_go        = 1'b0;
            i_move_done = 1'b0;
            if (o_move_en) begin
                if (en_cnt < 8) begin
                    en_cyc[en_cnt] = c;
                    en_s[en_cnt]   = o_start_block;
                    en_e[en_cnt]   = o_end_block;
                end
                en_cnt++;
                last_en = c;
            end
            if (c == last_en + delay) i_move_done = 1'b1;
            if (o_all_done) begin
                ad_cnt++;
                ad_cyc = c;
            end
        end
        i_move_done = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_push = 1'b0; i_push_start = 5'd0; i_push_end = 5'd0;
        i_go = 1'b0; i_abort = 1'b0; i_move_done = 1'b0;
        tick();
        tick();
        checks++; if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b want=1", o_empty); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_move_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_move_en got=%b want=0", o_move_en); end
        checks++; if (o_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b want=0", o_full); end
        checks++; if (o_moves_done !== 8'd0) begin failures++; $display("[TB] FAIL reset_moves_done got=%0d want=0", o_moves_done); end
        checks++; if ({o_err_move, o_err_timeout, o_all_done} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b want=000", {o_err_move, o_err_timeout, o_all_done}); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        push_move(5'd0, 5'd1);
        checks++; if (o_empty !== 1'b0) begin failures++; $display("[TB] FAIL push_empty got=%b want=0", o_empty); end
        push_move(5'd6, 5'd10);
        push_move(5'd7, 5'd6);
        i_go = 1'b1;
        run_model(130, 30);
        checks++; if (en_cnt !== 3) begin failures++; $display("[TB] FAIL basic_en_count got=%0d want=3", en_cnt); end
        checks++; if (en_cyc[0] !== 1) begin failures++; $display("[TB] FAIL basic_en0_cycle got=%0d want=1", en_cyc[0]); end
        checks++; if (en_cyc[1] !== 36) begin failures++; $display("[TB] FAIL basic_en1_cycle got=%0d want=36", en_cyc[1]); end
        checks++; if (en_cyc[2] !== 71) begin failures++; $display("[TB] FAIL basic_en2_cycle got=%0d want=71", en_cyc[2]); end
        checks++; if ({en_s[0], en_e[0]} !== {5'd0, 5'd1}) begin failures++; $display("[TB] FAIL basic_move0 got=%0d->%0d want=0->1", en_s[0], en_e[0]); end
        checks++; if ({en_s[1], en_e[1]} !== {5'd6, 5'd10}) begin failures++; $display("[TB] FAIL basic_move1 got=%0d->%0d want=6->10", en_s[1], en_e[1]); end
        checks++; if ({en_s[2], en_e[2]} !== {5'd7, 5'd6}) begin failures++; $display("[TB] FAIL basic_move2 got=%0d->%0d want=7->6", en_s[2], en_e[2]); end
        checks++; if (ad_cnt !== 1) begin failures++; $display("[TB] FAIL basic_all_done_count got=%0d want=1", ad_cnt); end
        checks++; if (ad_cyc !== 106) begin failures++; $display("[TB] FAIL basic_all_done_cycle got=%0d want=106", ad_cyc); end
        checks++; if (o_moves_done !== 8'd3) begin failures++; $display("[TB] FAIL basic_moves_done got=%0d want=3", o_moves_done); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_after got=%b want=0", o_busy); end
        checks++; if ({o_start_block, o_end_block} !== {5'd7, 5'd6}) begin failures++; $display("[TB] FAIL basic_index_hold got=%0d->%0d want=7->6", o_start_block, o_end_block); end
    endtask

    task automatic test_reject();
        push_move(5'd3, 5'd20);
        checks++; if (o_err_move !== 1'b1) begin failures++; $display("[TB] FAIL reject_range_err got=%b want=1", o_err_move); end
        checks++; if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL reject_range_empty got=%b want=1", o_empty); end
        push_move(5'd5, 5'd5);
        checks++; if (o_empty !== 1'b1) begin failures++; $display("[TB] FAIL reject_same_empty got=%b want=1", o_empty); end
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        checks++; if (o_all_done !== 1'b1) begin failures++; $display("[TB] FAIL empty_go_all_done got=%b want=1", o_all_done); end
        checks++; if (o_err_move !== 1'b0) begin failures++; $display("[TB] FAIL go_clears_err got=%b want=0", o_err_move); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL empty_go_busy got=%b want=0", o_busy); end
        tick();
        checks++; if (o_all_done !== 1'b0) begin failures++; $display("[TB] FAIL all_done_pulse_width got=%b want=0", o_all_done); end
    endtask

    task automatic test_full();
        push_move(5'd1, 5'd2);
        push_move(5'd2, 5'd3);
        push_move(5'd4, 5'd8);
        push_move(5'd8, 5'd9);
        checks++; if (o_full !== 1'b1) begin failures++; $display("[TB] FAIL full_flag got=%b want=1", o_full); end
        push_move(5'd9, 5'd13);
        checks++; if (o_err_move !== 1'b1) begin failures++; $display("[TB] FAIL full_push_err got=%b want=1", o_err_move); end
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        checks++; if ({o_move_en, o_start_block, o_end_block} !== {1'b1, 5'd1, 5'd2}) begin failures++; $display("[TB] FAIL full_first_issue got=%b %0d->%0d want=1 1->2", o_move_en, o_start_block, o_end_block); end
        push_move(5'd18, 5'd19);
        checks++; if (o_full !== 1'b1) begin failures++; $display("[TB] FAIL push_pop_full got=%b want=1", o_full); end
        checks++; if (o_err_move !== 1'b0) begin failures++; $display("[TB] FAIL push_pop_err got=%b want=0", o_err_move); end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++; if ({o_empty, o_full, o_busy} !== 3'b101) begin failures++; $display("[TB] FAIL full_abort_flush got=%b want=101", {o_empty, o_full, o_busy}); end
        i_move_done = 1'b1;
        tick();
        i_move_done = 1'b0;
        checks++; if ({o_busy, o_all_done} !== 2'b00) begin failures++; $display("[TB] FAIL full_abort_idle got=%b want=00", {o_busy, o_all_done}); end
        checks++; if (o_moves_done !== 8'd1) begin failures++; $display("[TB] FAIL full_abort_moves got=%0d want=1", o_moves_done); end
    endtask

    task automatic test_abort();
        int extra_en;
        int extra_ad;
        push_move(5'd0, 5'd4);
        push_move(5'd4, 5'd5);
        push_move(5'd5, 5'd9);
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        checks++; if ({o_move_en, o_start_block, o_end_block} !== {1'b1, 5'd0, 5'd4}) begin failures++; $display("[TB] FAIL abort_first_issue got=%b %0d->%0d want=1 0->4", o_move_en, o_start_block, o_end_block); end
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        checks++; if ({o_empty, o_busy} !== 2'b11) begin failures++; $display("[TB] FAIL abort_flush got=%b want=11", {o_empty, o_busy}); end
        repeat (5) tick();
        checks++; if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_waits_done got=%b want=1", o_busy); end
        i_move_done = 1'b1;
        tick();
        i_move_done = 1'b0;
        checks++; if ({o_busy, o_all_done} !== 2'b00) begin failures++; $display("[TB] FAIL abort_idle got=%b want=00", {o_busy, o_all_done}); end
        checks++; if (o_moves_done !== 8'd1) begin failures++; $display("[TB] FAIL abort_moves got=%0d want=1", o_moves_done); end
        extra_en = 0;
        extra_ad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_move_en) extra_en++;
            if (o_all_done) extra_ad++;
        end
        checks++; if (extra_en !== 0) begin failures++; $display("[TB] FAIL abort_no_second_en got=%0d want=0", extra_en); end
        checks++; if (extra_ad !== 0) begin failures++; $display("[TB] FAIL abort_no_all_done got=%0d want=0", extra_ad); end
    endtask

    task automatic test_timeout();
        push_move(5'd10, 5'd11);
        push_move(5'd11, 5'd15);
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checks++; if ({o_busy, o_err_timeout} !== 2'b10) begin failures++; $display("[TB] FAIL timeout_early got=%b want=10", {o_busy, o_err_timeout}); end
        tick();
        checks++; if (o_err_timeout !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err got=%b want=1", o_err_timeout); end
        checks++; if ({o_busy, o_empty, o_all_done} !== 3'b010) begin failures++; $display("[TB] FAIL timeout_state got=%b want=010", {o_busy, o_empty, o_all_done}); end
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        checks++; if ({o_err_timeout, o_all_done} !== 2'b01) begin failures++; $display("[TB] FAIL timeout_clear got=%b want=01", {o_err_timeout, o_all_done}); end
    endtask

    task automatic test_done_in_issue_and_reset();
        push_move(5'd12, 5'd13);
        i_go = 1'b1;
        tick();
        i_go = 1'b0;
        i_move_done = 1'b1;
        tick();
        i_move_done = 1'b0;
        repeat (8) tick();
        checks++; if ({o_busy, o_moves_done} !== {1'b1, 8'd0}) begin failures++; $display("[TB] FAIL issue_done_ignored got=%b %0d want=1 0", o_busy, o_moves_done); end
        push_move(5'd13, 5'd14);
        checks++; if (o_empty !== 1'b0) begin failures++; $display("[TB] FAIL wait_push_accept got=%b want=0", o_empty); end
        #3;
        i_rst = 1'b1;
        #1;
        checks++; if ({o_busy, o_move_en, o_empty, o_full} !== 4'b0010) begin failures++; $display("[TB] FAIL async_reset_flags got=%b want=0010", {o_busy, o_move_en, o_empty, o_full}); end
        checks++; if ({o_start_block, o_end_block, o_moves_done} !== 18'd0) begin failures++; $display("[TB] FAIL async_reset_data got=%0d %0d %0d want=0 0 0", o_start_block, o_end_block, o_moves_done); end
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_reject();
        test_full();
        test_abort();
        test_timeout();
        test_done_in_issue_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/klotski_move_sequencer.md
# klotski_move_sequencer

Move queue and dispatcher directly upstream of the block-movement/motor stage of the Klotski robot. The solver pushes (start block, end block) moves into an internal FIFO. On a go command the sequencer issues moves one at a time as a single-cycle enable plus block indices. It waits for the movement stage's done, then a mechanical settle gap, before issuing the next move. It reports progress, completion, and errors to the control FSM.

## Interface
- DEPTH, 16: FIFO depth in moves; power of two, 2..256.
- SETTLE_CYCLES, 2_500_000: idle cycles between move done and next issue (50 ms at 50 MHz); must be ≥1.
- TIMEOUT_CYCLES, 500_000_000: max cycles waiting for move done (10 s at 50 MHz).
- i_Clk  in  1  system clock (50 MHz).
- i_rst  in  1  asynchronous, active-high reset.
- i_push  in  1  write one move into FIFO.
- i_push_start  in  5  source cell, 0..19 (row-major 4×5 board).
- i_push_end  in  5  destination cell, 0..19.
- i_go  in  1  start executing queued moves (sampled in IDLE only).
- i_abort  in  1  flush queue, stop after current move.
- i_move_done  in  1  done from movement stage.
- o_move_en  out  1  one-cycle issue strobe to movement stage.
- o_start_block  out  5  current move source cell.
- o_end_block  out  5  current move destination cell.
- o_busy  out  1  high in any state except IDLE.
- o_all_done  out  1  one-cycle pulse when queue drained normally.
- o_empty, o_full  out  1  FIFO flags.
- o_moves_done  out  8  accepted dones since last go; saturates at 255.
- o_err_move  out  1  sticky: rejected push (index >19, start==end, or push while full).
- o_err_timeout  out  1  sticky: TIMEOUT_CYCLES expired in WAIT_DONE.

## Operation
- Reset: FSM=IDLE; FIFO empty; all outputs 0 except o_empty=1.
- Push validation: accepted only if both indices ≤19, start≠end, and not full (a simultaneous pop frees a slot, so push while full with pop in the same cycle is accepted). Rejected pushes are dropped and set o_err_move.
- Sticky errors clear on reset or on an i_go accepted in IDLE.
- Pushes are accepted in every state.
- IDLE:
  - i_go with FIFO non-empty → ISSUE; clear o_moves_done.
  - i_go with FIFO empty → o_all_done pulse next cycle; stay IDLE.
- ISSUE (1 cycle):
  - Register FIFO head onto o_start_block/o_end_block, assert o_move_en, pop.
  - → WAIT_DONE.
  - i_move_done is ignored this cycle.
- WAIT_DONE:
  - On i_move_done: o_moves_done+1 (saturating) → SETTLE.
  - If TIMEOUT_CYCLES elapse with no done: set o_err_timeout, flush FIFO → IDLE, no o_all_done.
- SETTLE: count SETTLE_CYCLES, then:
  - FIFO non-empty and no abort pending → ISSUE.
  - Otherwise → IDLE, with o_all_done pulse only if no abort is pending.
- Abort:
  - Flushes FIFO in the same cycle.
  - In IDLE/ISSUE/SETTLE → IDLE next cycle.
  - In WAIT_DONE: sets abort_pending and keeps waiting for i_move_done (the magnet is holding a piece), then → IDLE directly, skipping SETTLE.
  - An aborted run never pulses o_all_done.
  - Push in the same cycle as abort is discarded.
- o_start_block/o_end_block hold their values until the next ISSUE.

## Timing
- i_go at cycle n (IDLE, non-empty) → o_move_en high at cycle n+1 only.
- i_move_done at cycle m in WAIT_DONE → next o_move_en at m+SETTLE_CYCLES+1; o_all_done instead at that cycle if queue empty.
- Indices valid on the same cycle as o_move_en and stable thereafter.
- Push at cycle k → o_empty deasserts at k+1.
- o_full/o_empty are registered and reflect the FIFO count after the cycle's push/pop.
- Reset asserted mid-move drops o_move_en/o_busy immediately (async) and empties the FIFO.

## Test plan
(SETTLE_CYCLES=4, TIMEOUT_CYCLES=100, DEPTH=4)
- Push (0→1), (6→10), (7→6); go; movement model returns done 30 cycles after each en → three en strobes with those indices, spacing 30+4+1 cycles; o_all_done once; o_moves_done=3; o_busy low after.
- Push (3→20), then (5→5) → both rejected, o_err_move=1, o_empty stays 1; go → o_all_done next cycle, o_err_move cleared.
- Fill 4 moves, push fifth → o_full=1, fifth dropped, o_err_move=1. Push fifth in the ISSUE cycle of a running queue → accepted.
- Go with 3 moves, assert i_abort during first WAIT_DONE → FIFO empty at once; after done → IDLE, no o_all_done, o_moves_done=1, no second en.
- Go, never return done → o_err_timeout=1 after 100 cycles in WAIT_DONE; FIFO flushed; o_busy=0.
- i_move_done held high during ISSUE cycle → ignored; FSM still in WAIT_DONE until a later done; i_rst mid-WAIT_DONE → all outputs to reset values.
